// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch slice.
//   fetch_state_e : controller FSM encoding (IDLE / FETCH / REDIRECT)
//   PC_STEP       : byte increment between sequential fetches
//   INSTR_W       : instruction width
//   DEF_ADDR_W / DEF_DEPTH : default address width / fetch-queue depth
package fetch_pkg;
  localparam int PC_STEP    = 4;
  localparam int INSTR_W    = 32;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEPTH  = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry circular FIFO of {instr, pc} pairs.
//   clk, reset      : clock, synchronous active-high reset
//   push/push_instr/push_pc : enqueue request and payload
//   pop             : dequeue the head (ignored when empty)
//   flush           : drop every entry; wins over push and pop
//   out_valid/out_instr/out_pc : head entry, zero when empty
//   count           : number of held entries
// A push while full is accepted only when a pop frees the head slot in the
// same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic               pop,
  input  logic               flush,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [CNT_W-1:0]   count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [DEPTH-1:0][INSTR_W-1:0] instr_q;
  logic [DEPTH-1:0][ADDR_W-1:0]  pc_q;
  logic [PTR_W-1:0]              rd_ptr, wr_ptr;
  logic                          pop_e, push_e;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign out_valid = (count != '0);
  assign pop_e     = pop && out_valid;
  assign push_e    = push && ((count != CNT_MAX) || pop_e);

  // Head is forced to zero when empty so the outputs never carry stale data.
  assign out_instr = out_valid ? instr_q[rd_ptr] : '0;
  assign out_pc    = out_valid ? pc_q[rd_ptr]    : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_e) begin
        instr_q[wr_ptr] <= push_instr;
        pc_q[wr_ptr]    <= push_pc;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop_e) rd_ptr <= ptr_inc(rd_ptr);
      case ({push_e, pop_e})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: PC register, fetch FSM and fetch queue front end.
//   clk, reset          : clock, synchronous active-high reset
//   fetch_en            : allow new fetches (queue keeps draining when low)
//   redirect_valid/redirect_target : one-cycle branch/jump redirect
//   imem_addr/imem_data : combinational instruction-memory read port
//   out_valid/out_ready/out_instr/out_pc : decode-side handshake
//   misalign_err        : sticky misaligned-redirect flag, present only
//                         when IFETCH_ALIGN_CHECK_EN is defined
// Optional feature macro: IFETCH_ALIGN_CHECK_EN (redirect alignment check).
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
`ifdef IFETCH_ALIGN_CHECK_EN
  ,output logic              misalign_err
`endif
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  fetch_state_e        state, state_nxt;
  logic [ADDR_W-1:0]   pc, pc_nxt, tgt_eff;
  logic [CNT_W-1:0]    q_count;
  logic                q_pop, do_fetch;

  assign imem_addr = pc;
  assign q_pop     = out_valid && out_ready;

`ifdef IFETCH_ALIGN_CHECK_EN
  // Misaligned targets are rounded down to a word boundary and flagged.
  assign tgt_eff = {redirect_target[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset)
      misalign_err <= 1'b0;
    else if (redirect_valid && (redirect_target[1:0] != 2'b00))
      misalign_err <= 1'b1;
  end
`else
  assign tgt_eff = redirect_target;
`endif

  // Redirect beats everything; a full queue only accepts a fetch when the
  // head leaves in the same cycle. PC wraps naturally at ADDR_W bits.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    do_fetch  = 1'b0;
    if (redirect_valid) begin
      state_nxt = REDIRECT;
      pc_nxt    = tgt_eff;
    end else begin
      case (state)
        IDLE: if (fetch_en) state_nxt = FETCH;
        FETCH: begin
          if (!fetch_en) begin
            state_nxt = IDLE;
          end else if ((q_count != CNT_MAX) || q_pop) begin
            do_fetch = 1'b1;
            pc_nxt   = pc + ADDR_W'(PC_STEP);
          end
        end
        // One bubble: the target is fetched in the following FETCH cycle.
        REDIRECT: state_nxt = fetch_en ? FETCH : IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  fetch_queue #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (do_fetch),
    .push_instr (imem_data),
    .push_pc    (pc),
    .pop        (q_pop),
    .flush      (redirect_valid),
    .out_valid  (out_valid),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .count      (q_count)
  );
endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;
  logic        clk = 1'b0;
  logic        reset, fetch_en, redirect_valid, out_ready;
  logic [7:0]  redirect_target, imem_addr, out_pc;
  logic [31:0] imem_data, out_instr;
  logic        out_valid;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // Instruction memory: two fixed words at 0 and 4, address-tagged elsewhere.
  always_comb begin
    imem_data = 32'hC0DE0000 | {24'h0, imem_addr};
    if (imem_addr == 8'h00) imem_data = 32'h11111111;
    if (imem_addr == 8'h04) imem_data = 32'h22222222;
  end

  fetch_controller #(.ADDR_W(8), .DEPTH(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_en        (fetch_en),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc)
`ifdef IFETCH_ALIGN_CHECK_EN
    ,.misalign_err   (misalign_err)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic head(input string tag, input logic v, input logic [7:0] pc,
                      input logic [31:0] ins);
    chk({tag, ".valid"}, {31'h0, out_valid}, {31'h0, v});
    chk({tag, ".pc"}, {24'h0, out_pc}, {24'h0, pc});
    chk({tag, ".instr"}, out_instr, ins);
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
    redirect_target = 8'h00; out_ready = 1'b0;
    step(); step();
    head("reset", 1'b0, 8'h00, 32'h0);
    chk("reset.addr", {24'h0, imem_addr}, 32'h0);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("reset.misalign", {31'h0, misalign_err}, 32'h0);
`endif

    // Sequential stream: IDLE->FETCH, then one enqueue per cycle.
    reset = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    step();
    chk("idle2fetch.valid", {31'h0, out_valid}, 32'h0);
    chk("idle2fetch.addr", {24'h0, imem_addr}, 32'h0);
    step();
    head("seq0", 1'b1, 8'h00, 32'h11111111);
    chk("seq0.addr", {24'h0, imem_addr}, 32'h4);
    step();
    head("seq1", 1'b1, 8'h04, 32'h22222222);
    chk("seq1.addr", {24'h0, imem_addr}, 32'h8);

    // Stall: queue fills with pc 4,8 and the PC holds at 12.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      head("stall", 1'b1, 8'h04, 32'h22222222);
      chk("stall.addr", {24'h0, imem_addr}, 32'h0C);
    end
    out_ready = 1'b1;
    step();
    head("drain0", 1'b1, 8'h08, 32'hC0DE0008);
    step();
    head("drain1", 1'b1, 8'h0C, 32'hC0DE000C);

    // Redirect with a full queue: flush, one bubble, then the target stream.
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 8'h40;
    step();
    chk("redir.valid", {31'h0, out_valid}, 32'h0);
    chk("redir.addr", {24'h0, imem_addr}, 32'h40);
    redirect_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("bubble.valid", {31'h0, out_valid}, 32'h0);
    step();
    head("tgt0", 1'b1, 8'h40, 32'hC0DE0040);
    step();
    head("tgt1", 1'b1, 8'h44, 32'hC0DE0044);

    // PC wrap at 2^8.
    redirect_valid = 1'b1; redirect_target = 8'hF8;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    head("wrap0", 1'b1, 8'hF8, 32'hC0DE00F8);
    step();
    head("wrap1", 1'b1, 8'hFC, 32'hC0DE00FC);
    step();
    head("wrap2", 1'b1, 8'h00, 32'h11111111);

    // fetch_en low: PC holds, the held entry stays and then drains.
    fetch_en = 1'b0; out_ready = 1'b0;
    step(); step();
    head("hold", 1'b1, 8'h00, 32'h11111111);
    chk("hold.addr", {24'h0, imem_addr}, 32'h04);
    out_ready = 1'b1;
    step();
    chk("drained.valid", {31'h0, out_valid}, 32'h0);
    chk("drained.addr", {24'h0, imem_addr}, 32'h04);

    // Reset beats a redirect with two queued entries.
    fetch_en = 1'b1; out_ready = 1'b0;
    step(); step(); step();
    head("prefill", 1'b1, 8'h04, 32'h22222222);
    chk("prefill.addr", {24'h0, imem_addr}, 32'h0C);
    reset = 1'b1; redirect_valid = 1'b1; redirect_target = 8'h80;
    step();
    head("midrst", 1'b0, 8'h00, 32'h0);
    chk("midrst.addr", {24'h0, imem_addr}, 32'h0);
    reset = 1'b0; redirect_valid = 1'b0; fetch_en = 1'b0;
    step();
    chk("postrst.valid", {31'h0, out_valid}, 32'h0);
    chk("postrst.addr", {24'h0, imem_addr}, 32'h0);

`ifdef IFETCH_ALIGN_CHECK_EN
    fetch_en = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_target = 8'h42;
    step();
    redirect_valid = 1'b0;
    chk("mis.set", {31'h0, misalign_err}, 32'h1);
    chk("mis.addr", {24'h0, imem_addr}, 32'h40);
    step(); step();
    head("mis.head", 1'b1, 8'h40, 32'hC0DE0040);
    redirect_valid = 1'b1; redirect_target = 8'h80;
    step();
    redirect_valid = 1'b0;
    chk("mis.sticky", {31'h0, misalign_err}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mis.clear", {31'h0, misalign_err}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning instruction memory byte-address width.
REQ-002 SHALL have parameter DEPTH, default 2, meaning fetch-queue entries.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 fetch_en  input  1  permits new fetches; low = hold PC, queue still drains.
REQ-006 redirect_valid  input  1  branch/jump redirect request, one-cycle pulse.
REQ-007 redirect_target  input  ADDR_W  byte address of the new fetch stream.
REQ-008 imem_addr  output  ADDR_W  byte address to instruction memory (combinational read port).
REQ-009 imem_data  input  32  big-endian instruction returned in the same cycle for imem_addr.
REQ-010 out_valid  output  1  queue head holds a valid instruction.
REQ-011 out_ready  input  1  decode stage accepts the head this cycle.
REQ-012 out_instr  output  32  instruction at the queue head.
REQ-013 out_pc  output  ADDR_W  byte address of out_instr.
REQ-014 misalign_err  output  1  sticky misaligned-redirect flag (only with IFETCH_ALIGN_CHECK_EN).

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, REDIRECT; reset state IDLE.
REQ-016 IDLE->FETCH when fetch_en=1; FETCH->IDLE when fetch_en=0; any state->REDIRECT on redirect_valid=1; REDIRECT->FETCH if fetch_en=1, else IDLE.
REQ-017 imem_addr SHALL equal the PC register combinationally in every state.
REQ-018 In FETCH, when count<DEPTH or a dequeue occurs the same cycle, {imem_data, PC} SHALL be enqueued and PC SHALL advance by 4.
REQ-019 PC arithmetic SHALL be modulo 2^ADDR_W: 252 + 4 -> 0 with ADDR_W=8, no flag.
REQ-020 Dequeue occurs when out_valid=1 and out_ready=1; out_instr/out_pc SHALL reflect the head with zero added latency.
REQ-021 Fetch-to-out_valid latency SHALL be one cycle: enqueue at edge N, out_valid=1 after edge N.
REQ-022 In the redirect cycle: queue flushed (count->0), PC<=target, no enqueue, any same-cycle dequeue by the consumer SHALL still be treated as dropped (redirect wins over enqueue and dequeue).
REQ-023 The REDIRECT state SHALL insert exactly one bubble: no enqueue in the cycle after the redirect pulse; first target fetch occurs in the next FETCH cycle.
REQ-024 Queue full with out_ready=0: PC SHALL hold, imem_addr stable, no overwrite.
REQ-025 Queue empty: out_valid=0; out_instr/out_pc are don't-care but SHALL not be X after reset (drive 0).
REQ-026 fetch_en=0 SHALL not flush the queue; held entries drain normally.

Reset
REQ-027 On reset=1 at a clock edge: PC=0, count=0, state=IDLE, out_valid=0, out_instr=0, out_pc=0, misalign_err=0.
REQ-028 Reset SHALL override redirect_valid and any enqueue/dequeue in the same cycle; reset mid-stream discards all queued entries.

Configuration
REQ-029 Macro IFETCH_ALIGN_CHECK_EN defined: a redirect with target[1:0]!=0 SHALL set misalign_err (sticky until reset) and load PC with target[1:0] forced to 00.
REQ-030 Macro undefined: misalign_err port absent; target loaded unmodified.

Structure
REQ-031 Package fetch_pkg SHALL hold the FSM state enum, PC_STEP=4, INSTR_W=32 and default ADDR_W/DEPTH constants.
REQ-032 Queue SHALL be a sub-module fetch_queue (DEPTH entries, push/pop/flush, count); FSM and PC remain in fetch_controller.

Verification
REQ-033 Reset then fetch_en=1, out_ready=1, memory holding 0x11111111@0, 0x22222222@4 -> imem_addr 0,4,8...; out_valid from cycle 1; out_pc 0,4 with matching instr.
REQ-034 out_ready=0 for 5 cycles -> queue fills to 2 entries (pc 0,4), imem_addr holds at 8; release -> pc 0,4,8 in order, no loss/duplicate.
REQ-035 Redirect target=0x40 while queue full -> next cycle out_valid=0; one bubble; then out_pc=0x40, 0x44.
REQ-036 Start PC=0xF8 via redirect -> out_pc 0xF8, 0xFC, 0x00 (wrap).
REQ-037 Reset asserted with 2 queued entries and redirect_valid=1 -> all outputs at reset values, state IDLE, PC=0.
REQ-038 With IFETCH_ALIGN_CHECK_EN: redirect target=0x42 -> misalign_err=1 sticky, next out_pc=0x40; cleared only by reset.
